slot_alloc_32: RTL and testbench

- 32-entry free-slot allocator for in-flight tracking tables (e.g. load/store or miss-buffer IDs).
- Keeps an occupancy bitmap and picks the lowest-numbered free slot through a one-hot priority pick followed by a 32-to-5 encode.
- Takes one allocation and one release per cycle. Alloc results go to the issuing stage; release indices come from the completing stage.

---
 rtl/slot_alloc_32.sv | 132 +++++++++++++
 tb/tb_slot_alloc_32.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/slot_alloc_32.sv
// ---------------------------------------------------------------------------
// slot_alloc_32 -- 32-entry free-slot allocator
//
// Tracks which of 32 tracking-table slots are in flight using an occupancy
// bitmap. Each cycle it grants the lowest-numbered free slot and accepts one
// release. Slots set in RSV_MASK are permanently occupied: they are never
// granted, their releases are ignored and they are not counted in used_cnt.
//
// Optional feature: define SLOT_ALLOC_ERR_CHK_EN to build the sticky
// double-free detector. Without it, err_double_free is tied to 0.
//
// Ports:
//   clk             in   rising-edge clock
//   resetn          in   asynchronous reset, active-low
//   flush           in   synchronous clear of all non-reserved slots
//   alloc_req       in   requester wants a slot this cycle
//   alloc_gnt       out  slot granted this cycle (combinational)
//   alloc_idx[4:0]  out  granted slot index (0 when full)
//   free_valid      in   release request
//   free_idx[4:0]   in   slot to release
//   used_cnt[5:0]   out  occupied non-reserved slots, 0..32
//   full            out  no free slot
//   empty           out  used_cnt == 0
//   err_double_free out  sticky release-of-free/reserved-slot flag
// ---------------------------------------------------------------------------
module slot_alloc_32 #(
  parameter logic [31:0] RSV_MASK = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       flush,
  input  logic       alloc_req,
  output logic       alloc_gnt,
  output logic [4:0] alloc_idx,
  input  logic       free_valid,
  input  logic [4:0] free_idx,
  output logic [5:0] used_cnt,
  output logic       full,
  output logic       empty,
  output logic       err_double_free
);

  logic [31:0] rsv_mask;
  logic [31:0] occ_q, occ_d;
  logic [5:0]  used_cnt_q, used_cnt_d;
  logic [31:0] free_vec;
  logic [31:0] pick_onehot;
  logic [4:0]  pick_idx;
  logic        rel_ok;

  assign rsv_mask = RSV_MASK;

  // -------------------------------------------------------------------------
  // Status and lowest-free-slot pick, all from registered state
  // -------------------------------------------------------------------------
  assign full     = &occ_q;
  assign empty    = (used_cnt_q == 6'd0);
  assign used_cnt = used_cnt_q;
  assign free_vec = ~occ_q;

  // x & -x isolates the lowest set bit; all-zero when no slot is free.
  assign pick_onehot = free_vec & (~free_vec + 32'd1);

  // One-hot to binary: OR together the indices of set bits. With at most one
  // bit set this is exact, and an all-zero vector encodes to 5'd0.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first,
    // so every path drives the output and no latch is inferred.
    pick_idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (pick_onehot[i]) pick_idx = pick_idx | 5'(i);
    end
  end

  assign alloc_idx = pick_idx;
  assign alloc_gnt = alloc_req & ~full & ~flush;

  // A release of the slot being granted this cycle sees occ=0 for that slot,
  // so it falls out as an ignored release with no special casing.
  assign rel_ok = free_valid & ~flush & occ_q[free_idx] & ~rsv_mask[free_idx];

  // -------------------------------------------------------------------------
  // Next-state for occupancy and count
  // -------------------------------------------------------------------------
  always_comb begin
    occ_d      = occ_q;
    used_cnt_d = used_cnt_q;
    if (alloc_gnt) occ_d = occ_d | pick_onehot;
    if (rel_ok)    occ_d[free_idx] = 1'b0;
    unique case ({alloc_gnt, rel_ok})
      2'b10:   used_cnt_d = used_cnt_q + 6'd1;
      2'b01:   used_cnt_d = used_cnt_q - 6'd1;
      default: used_cnt_d = used_cnt_q;
    endcase
    if (flush) begin
      occ_d      = rsv_mask;
      used_cnt_d = 6'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values; the bitmap is plain flops, so it takes a reset value.
    if (!resetn) begin
      occ_q      <= RSV_MASK;
      used_cnt_q <= 6'd0;
    end else begin
      occ_q      <= occ_d;
      used_cnt_q <= used_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky double-free detector
  // -------------------------------------------------------------------------
`ifdef SLOT_ALLOC_ERR_CHK_EN
  logic err_q, err_d;

  // Flush cycles are excluded: a release during flush is overridden, not bad.
  assign err_d = err_q | (free_valid & ~flush & ~rel_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_double_free = err_q;
`else
  assign err_double_free = 1'b0;
`endif

endmodule

// File: tb/tb_slot_alloc_32.sv
// ---------------------------------------------------------------------------
// tb_slot_alloc_32 -- scoreboard bench for slot_alloc_32
//
// Main instance (RSV_MASK=0) is checked by a monitor that pops the expected
// grant index whenever alloc_gnt is seen. A second instance (RSV_MASK=1) and
// a third (all reserved) are checked directly with hand-computed values.
// ---------------------------------------------------------------------------
module tb_slot_alloc_32;

`ifdef SLOT_ALLOC_ERR_CHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;

  // Main DUT
  logic       flush, alloc_req, free_valid;
  logic [4:0] free_idx;
  logic       alloc_gnt, full, empty, err_double_free;
  logic [4:0] alloc_idx;
  logic [5:0] used_cnt;

  // RSV_MASK = 1 instance
  logic       r_flush, r_alloc_req, r_free_valid;
  logic [4:0] r_free_idx;
  logic       r_alloc_gnt, r_full, r_empty, r_err;
  logic [4:0] r_alloc_idx;
  logic [5:0] r_used_cnt;

  // All-reserved instance
  logic       a_alloc_req, a_free_valid;
  logic       a_alloc_gnt, a_full, a_empty, a_err;
  logic [4:0] a_alloc_idx;
  logic [5:0] a_used_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  slot_alloc_32 dut (
    .clk(clk), .resetn(resetn), .flush(flush), .alloc_req(alloc_req),
    .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx), .free_valid(free_valid),
    .free_idx(free_idx), .used_cnt(used_cnt), .full(full), .empty(empty),
    .err_double_free(err_double_free)
  );

  slot_alloc_32 #(.RSV_MASK(32'h0000_0001)) dut_rsv (
    .clk(clk), .resetn(resetn), .flush(r_flush), .alloc_req(r_alloc_req),
    .alloc_gnt(r_alloc_gnt), .alloc_idx(r_alloc_idx), .free_valid(r_free_valid),
    .free_idx(r_free_idx), .used_cnt(r_used_cnt), .full(r_full), .empty(r_empty),
    .err_double_free(r_err)
  );

  slot_alloc_32 #(.RSV_MASK(32'hFFFF_FFFF)) dut_all (
    .clk(clk), .resetn(resetn), .flush(1'b0), .alloc_req(a_alloc_req),
    .alloc_gnt(a_alloc_gnt), .alloc_idx(a_alloc_idx), .free_valid(a_free_valid),
    .free_idx(5'd3), .used_cnt(a_used_cnt), .full(a_full), .empty(a_empty),
    .err_double_free(a_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every grant on the main DUT must match the next queued index.
  always @(negedge clk) begin
    if (resetn === 1'b1 && alloc_gnt === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(alloc_idx), 32'h7fff_ffff);
      end else begin
        check("grant_idx", 32'(alloc_idx), 32'(exp_q.pop_front()));
      end
    end
  end

  // Apply inputs just after a rising edge, return at the following falling
  // edge where combinational outputs are stable and can be compared.
  task automatic drive(input logic req, input logic fv, input logic [4:0] fi, input logic fl);
    @(posedge clk); #1;
    alloc_req = req; free_valid = fv; free_idx = fi; flush = fl;
    @(negedge clk);
  endtask

  task automatic drive_r(input logic req, input logic fv, input logic [4:0] fi);
    @(posedge clk); #1;
    r_alloc_req = req; r_free_valid = fv; r_free_idx = fi;
    @(negedge clk);
  endtask

  task automatic alloc_n(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(5'(first + i));
      drive(1'b1, 1'b0, 5'd0, 1'b0);
      check("used_cnt_during_fill", 32'(used_cnt), 32'(i));
    end
  endtask

  task automatic check_all_reserved(input string tag);
    check({tag, "_all_full"}, 32'(a_full), 32'd1);
    check({tag, "_all_gnt"}, 32'(a_alloc_gnt), 32'd0);
    check({tag, "_all_used"}, 32'(a_used_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    flush = 1'b0; alloc_req = 1'b0; free_valid = 1'b0; free_idx = 5'd0;
    r_flush = 1'b0; r_alloc_req = 1'b0; r_free_valid = 1'b0; r_free_idx = 5'd0;
    a_alloc_req = 1'b1; a_free_valid = 1'b1;
    #12 resetn = 1'b1;
    #1;

    // Reset state
    check("rst_used_cnt", 32'(used_cnt), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err_double_free), 32'd0);
    check("rst_alloc_idx", 32'(alloc_idx), 32'd0);
    check_all_reserved("rst");

    // Fill all 32 slots in order, then a 33rd request is refused.
    alloc_n(32, 0);
    drive(1'b1, 1'b0, 5'd0, 1'b0);
    check("fill_used_cnt", 32'(used_cnt), 32'd32);
    check("fill_full", 32'(full), 32'd1);
    check("fill_gnt_when_full", 32'(alloc_gnt), 32'd0);
    check("fill_idx_when_full", 32'(alloc_idx), 32'd0);

    // Release 7 while full: no same-cycle grant; 7 is granted next cycle.
    drive(1'b1, 1'b1, 5'd7, 1'b0);
    check("rel_same_cycle_gnt", 32'(alloc_gnt), 32'd0);
    exp_q.push_back(5'd7);
    drive(1'b1, 1'b0, 5'd0, 1'b0);
    check("rel_used_after_free", 32'(used_cnt), 32'd31);
    drive(1'b0, 1'b0, 5'd0, 1'b0);
    check("rel_used_refill", 32'(used_cnt), 32'd32);
    check("rel_full_refill", 32'(full), 32'd1);

    // Flush, hold 0..3, then alloc + free(1) together.
    drive(1'b0, 1'b0, 5'd0, 1'b1);
    drive(1'b0, 1'b0, 5'd0, 1'b0);
    check("flush1_used", 32'(used_cnt), 32'd0);
    check("flush1_empty", 32'(empty), 32'd1);
    alloc_n(4, 0);
    exp_q.push_back(5'd4);
    drive(1'b1, 1'b1, 5'd1, 1'b0);
    check("simul_used_before", 32'(used_cnt), 32'd4);
    exp_q.push_back(5'd1);
    drive(1'b1, 1'b0, 5'd0, 1'b0);
    check("simul_used_net0", 32'(used_cnt), 32'd4);

    // Alloc and free of the same index: release ignored, alloc commits.
    exp_q.push_back(5'd5);
    drive(1'b1, 1'b1, 5'd5, 1'b0);
    check("same_idx_used_before", 32'(used_cnt), 32'd5);
    drive(1'b0, 1'b0, 5'd0, 1'b0);
    check("same_idx_used_after", 32'(used_cnt), 32'd6);
    check("same_idx_err", 32'(err_double_free), 32'(ERR_EN));

    // Flush overrides alloc and free in the same cycle.
    drive(1'b0, 1'b0, 5'd0, 1'b1);
    alloc_n(10, 0);
    drive(1'b1, 1'b1, 5'd3, 1'b1);
    check("flush_gnt", 32'(alloc_gnt), 32'd0);
    check("flush_used_before", 32'(used_cnt), 32'd10);
    drive(1'b0, 1'b0, 5'd0, 1'b0);
    check("flush_used_after", 32'(used_cnt), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_idx", 32'(alloc_idx), 32'd0);
    check("flush_err_kept", 32'(err_double_free), 32'(ERR_EN));

    // Asynchronous reset between edges with 5 slots held.
    alloc_n(5, 0);
    drive(1'b0, 1'b0, 5'd0, 1'b0);
    check("pre_async_used", 32'(used_cnt), 32'd5);
    #2 resetn = 1'b0;
    #1;
    check("async_used", 32'(used_cnt), 32'd0);
    check("async_empty", 32'(empty), 32'd1);
    check("async_idx", 32'(alloc_idx), 32'd0);
    check("async_err", 32'(err_double_free), 32'd0);
    #1 resetn = 1'b1;
    exp_q.push_back(5'd0);
    drive(1'b1, 1'b0, 5'd0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 1'b0);
    check("post_async_used", 32'(used_cnt), 32'd1);

    // Reserved slot 0: first grant is 1, release of 0 is ignored.
    drive_r(1'b1, 1'b0, 5'd0);
    check("rsv_gnt", 32'(r_alloc_gnt), 32'd1);
    check("rsv_first_idx", 32'(r_alloc_idx), 32'd1);
    drive_r(1'b0, 1'b1, 5'd0);
    check("rsv_used_after_alloc", 32'(r_used_cnt), 32'd1);
    drive_r(1'b1, 1'b0, 5'd0);
    check("rsv_used_after_bad_free", 32'(r_used_cnt), 32'd1);
    check("rsv_err", 32'(r_err), 32'(ERR_EN));
    check("rsv_next_idx", 32'(r_alloc_idx), 32'd2);
    drive_r(1'b0, 1'b0, 5'd0);
    check("rsv_used_final", 32'(r_used_cnt), 32'd2);

    check_all_reserved("end");
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
